// File: rtl/afp3_eng_rtry_dispatch.sv
// Retry dispatcher: decodes retry-queue entries and pulses the owning
// sequencer's start, either immediately or after a per-channel backoff.
module afp3_eng_rtry_dispatch #(
    parameter int NUM_SEQ   = 11,
    parameter int CH_W      = 4,
    parameter int TAG_W     = 5,
    parameter int CNT_W     = 8,
    parameter int CPY_LD_CH = 3,
    parameter int CPY_ST_CH = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   mmio_eng_enable,
    input  logic                   mmio_eng_resend_retries,
    input  logic [CNT_W-1:0]       mmio_backoff_limit,
    input  logic                   rtry_vld,
    output logic                   rtry_rdy,
    input  logic [TAG_W-1:0]       rtry_afutag,
    input  logic                   rtry_cpy_xx,
    input  logic                   rtry_cpy_st,
    input  logic                   rtry_is_pending,
    input  logic                   rtry_is_rtry_lwt,
    input  logic                   rtry_is_rtry_req,
    input  logic                   rtry_is_rtry_hwt,
    input  logic                   resp_code_is_done,
    input  logic                   resp_code_is_rty_req,
    input  logic                   resp_code_is_failed,
    input  logic                   resp_code_is_adr_error,
    input  logic [NUM_SEQ-1:0]     seq_wt4rsp,
    output logic [NUM_SEQ-1:0]     start_rtry_seq,
    output logic [4*NUM_SEQ-1:0]   rtry_kind,
    output logic                   rtry_drop,
    output logic [NUM_SEQ-1:0]     backoff_busy
);

    localparam int NCH = 2 ** CH_W;

    localparam logic [3:0] K_IMM = 4'b1000;
    localparam logic [3:0] K_BKO = 4'b0100;
    localparam logic [3:0] K_ABT = 4'b0010;
    localparam logic [3:0] K_HWT = 4'b1001;

    logic [CH_W-1:0]               ch;
    logic                          ch_inv;
    logic [NCH-1:0]                busy_pad;
    logic                          abort_all;
    logic                          abort_q;
    logic                          abort_rise;
    logic                          accept;
    logic [3:0]                    dec;

    logic [NUM_SEQ-1:0][CNT_W-1:0] cnt;
    logic [NUM_SEQ-1:0][CNT_W-1:0] cnt_n;
    logic [NUM_SEQ-1:0]            busy_n;
    logic [NUM_SEQ-1:0]            start_n;
    logic [4*NUM_SEQ-1:0]          kind_n;
    logic                          drop_n;

    assign ch = rtry_cpy_xx ? (rtry_cpy_st ? CH_W'(CPY_ST_CH) : CH_W'(CPY_LD_CH))
                            : rtry_afutag[CH_W-1:0];
    assign ch_inv     = 32'(ch) >= NUM_SEQ;
    assign busy_pad   = NCH'(backoff_busy);
    assign rtry_rdy   = ~busy_pad[ch] | ch_inv;
    assign accept     = rtry_vld & rtry_rdy;
    assign abort_all  = ~mmio_eng_enable & ~mmio_eng_resend_retries;
    assign abort_rise = abort_all & ~abort_q;

    always_comb begin
        dec = 4'b0000;
        if (!rtry_is_pending && (rtry_is_rtry_lwt || rtry_is_rtry_req))
            dec = abort_all ? K_ABT : K_BKO;
        else if (!rtry_is_pending && rtry_is_rtry_hwt)
            dec = abort_all ? K_ABT : K_HWT;
        else if (rtry_is_pending && abort_all)
            dec = K_ABT;
        else if (rtry_is_pending && resp_code_is_done)
            dec = K_IMM;
        else if (rtry_is_pending && resp_code_is_rty_req)
            dec = K_BKO;
        else if (rtry_is_pending && (resp_code_is_failed || resp_code_is_adr_error))
            dec = K_ABT;
    end

    always_comb begin
        start_n = '0;
        kind_n  = '0;
        drop_n  = 1'b0;
        busy_n  = backoff_busy;
        cnt_n   = cnt;
        for (int i = 0; i < NUM_SEQ; i++) begin
            // An abort edge flushes every running backoff as an abort start.
            if (backoff_busy[i]) begin
                if (abort_rise || cnt[i] == '0) begin
                    busy_n[i] = 1'b0;
                    cnt_n[i]  = '0;
                    if (seq_wt4rsp[i]) begin
                        start_n[i]       = 1'b1;
                        kind_n[4*i +: 4] = abort_rise ? K_ABT : K_BKO;
                    end else begin
                        drop_n = 1'b1;
                    end
                end else begin
                    cnt_n[i] = cnt[i] - 1'b1;
                end
            end
            if (accept && !ch_inv && dec != 4'b0000 && ch == CH_W'(i)) begin
                if (dec == K_BKO) begin
                    busy_n[i] = 1'b1;
                    cnt_n[i]  = mmio_backoff_limit;
                end else if (seq_wt4rsp[i]) begin
                    start_n[i]       = 1'b1;
                    kind_n[4*i +: 4] = dec;
                end else begin
                    drop_n = 1'b1;
                end
            end
        end
        if (accept && (ch_inv || dec == 4'b0000))
            drop_n = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt            <= '0;
            backoff_busy   <= '0;
            start_rtry_seq <= '0;
            rtry_kind      <= '0;
            rtry_drop      <= 1'b0;
            abort_q        <= 1'b0;
        end else begin
            cnt            <= cnt_n;
            backoff_busy   <= busy_n;
            start_rtry_seq <= start_n;
            rtry_kind      <= kind_n;
            rtry_drop      <= drop_n;
            abort_q        <= abort_all;
        end
    end

endmodule

// File: tb/tb_afp3_eng_rtry_dispatch.sv
// Randomized bench for afp3_eng_rtry_dispatch against a timestamp-based
// scheduler model of retry dispatch.
module tb_afp3_eng_rtry_dispatch;

    localparam int NS = 11;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          mmio_eng_enable;
    logic          mmio_eng_resend_retries;
    logic [7:0]    mmio_backoff_limit;
    logic          rtry_vld;
    logic          rtry_rdy;
    logic [4:0]    rtry_afutag;
    logic          rtry_cpy_xx;
    logic          rtry_cpy_st;
    logic          rtry_is_pending;
    logic          rtry_is_rtry_lwt;
    logic          rtry_is_rtry_req;
    logic          rtry_is_rtry_hwt;
    logic          resp_code_is_done;
    logic          resp_code_is_rty_req;
    logic          resp_code_is_failed;
    logic          resp_code_is_adr_error;
    logic [NS-1:0] seq_wt4rsp;
    logic [NS-1:0] start_rtry_seq;
    logic [4*NS-1:0] rtry_kind;
    logic          rtry_drop;
    logic [NS-1:0] backoff_busy;

    afp3_eng_rtry_dispatch dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .mmio_eng_enable        (mmio_eng_enable),
        .mmio_eng_resend_retries(mmio_eng_resend_retries),
        .mmio_backoff_limit     (mmio_backoff_limit),
        .rtry_vld               (rtry_vld),
        .rtry_rdy               (rtry_rdy),
        .rtry_afutag            (rtry_afutag),
        .rtry_cpy_xx            (rtry_cpy_xx),
        .rtry_cpy_st            (rtry_cpy_st),
        .rtry_is_pending        (rtry_is_pending),
        .rtry_is_rtry_lwt       (rtry_is_rtry_lwt),
        .rtry_is_rtry_req       (rtry_is_rtry_req),
        .rtry_is_rtry_hwt       (rtry_is_rtry_hwt),
        .resp_code_is_done      (resp_code_is_done),
        .resp_code_is_rty_req   (resp_code_is_rty_req),
        .resp_code_is_failed    (resp_code_is_failed),
        .resp_code_is_adr_error (resp_code_is_adr_error),
        .seq_wt4rsp             (seq_wt4rsp),
        .start_rtry_seq         (start_rtry_seq),
        .rtry_kind              (rtry_kind),
        .rtry_drop              (rtry_drop),
        .backoff_busy           (backoff_busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Spec decode table, {imm,bko,abt,hwt}.
    function automatic logic [3:0] decode(input bit ab);
        if (!rtry_is_pending) begin
            if (rtry_is_rtry_lwt || rtry_is_rtry_req) return ab ? 4'b0010 : 4'b0100;
            if (rtry_is_rtry_hwt) return ab ? 4'b0010 : 4'b1001;
            return 4'b0000;
        end
        if (ab) return 4'b0010;
        if (resp_code_is_done) return 4'b1000;
        if (resp_code_is_rty_req) return 4'b0100;
        if (resp_code_is_failed || resp_code_is_adr_error) return 4'b0010;
        return 4'b0000;
    endfunction

    // Model: a backoff accepted at cycle T fires at absolute cycle T+2+limit.
    bit        armed [NS];
    int        fire_at [NS];
    bit        abort_prev;
    bit        hold;
    logic [NS-1:0]   e_start, e_busy;
    logic [4*NS-1:0] e_kind;
    logic            e_drop;

    task automatic fire(input int i, input logic [3:0] k);
        if (seq_wt4rsp[i]) begin
            e_start[i]       = 1'b1;
            e_kind[4*i +: 4] = k;
        end else begin
            e_drop = 1'b1;
        end
    endtask

    task automatic rand_entry();
        rtry_vld               = ($urandom_range(0, 3) != 0);
        rtry_afutag            = 5'($urandom);
        rtry_cpy_xx            = ($urandom_range(0, 5) == 0);
        rtry_cpy_st            = 1'($urandom);
        rtry_is_pending        = 1'($urandom);
        rtry_is_rtry_lwt       = ($urandom_range(0, 2) == 0);
        rtry_is_rtry_req       = ($urandom_range(0, 3) == 0);
        rtry_is_rtry_hwt       = 1'($urandom);
        resp_code_is_done      = 1'($urandom);
        resp_code_is_rty_req   = 1'($urandom);
        resp_code_is_failed    = ($urandom_range(0, 3) == 0);
        resp_code_is_adr_error = ($urandom_range(0, 5) == 0);
    endtask

    function automatic void clear_model();
        for (int i = 0; i < NS; i++) armed[i] = 1'b0;
        e_start = '0; e_kind = '0; e_drop = 1'b0; e_busy = '0;
        abort_prev = 1'b0;
        hold = 1'b0;
    endfunction

    initial begin
        int cyc;
        int ch;
        bit inv, ab, rise, exp_rdy;
        logic [3:0] k;

        reset_n = 1'b0;
        mmio_eng_enable = 1'b1;
        mmio_eng_resend_retries = 1'b0;
        mmio_backoff_limit = 8'd5;
        seq_wt4rsp = '1;
        rand_entry();
        rtry_vld = 1'b0;
        clear_model();
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_start", 64'(start_rtry_seq), 64'(0));
        chk("reset_kind", 64'(rtry_kind), 64'(0));
        chk("reset_drop", 64'(rtry_drop), 64'(0));
        chk("reset_busy", 64'(backoff_busy), 64'(0));
        chk("reset_rdy", 64'(rtry_rdy), 64'(1));
        reset_n = 1'b1;
        cyc = 0;

        for (int n = 0; n < 4000; n++) begin
            if (n > 0) begin
                @(negedge clock);
                chk("start", 64'(start_rtry_seq), 64'(e_start));
                chk("kind", 64'(rtry_kind), 64'(e_kind));
                chk("drop", 64'(rtry_drop), 64'(e_drop));
                chk("busy", 64'(backoff_busy), 64'(e_busy));
            end
            reset_n = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 29) == 0)
                mmio_eng_enable = ~mmio_eng_enable;
            mmio_eng_resend_retries = ($urandom_range(0, 2) == 0);
            mmio_backoff_limit = 8'($urandom_range(0, 12));
            seq_wt4rsp = NS'($urandom) | NS'($urandom) | NS'($urandom);
            if (!hold) rand_entry();
            #1;
            if (!reset_n) begin
                clear_model();
            end else begin
                ab   = !mmio_eng_enable && !mmio_eng_resend_retries;
                rise = ab && !abort_prev;
                ch   = rtry_cpy_xx ? (rtry_cpy_st ? 4 : 3) : int'(rtry_afutag % 16);
                inv  = ch >= NS;
                exp_rdy = inv || !armed[ch];
                chk("rdy", 64'(rtry_rdy), 64'(exp_rdy));
                e_start = '0; e_kind = '0; e_drop = 1'b0;
                for (int i = 0; i < NS; i++) begin
                    if (armed[i] && (rise || cyc + 1 == fire_at[i])) begin
                        fire(i, rise ? 4'b0010 : 4'b0100);
                        armed[i] = 1'b0;
                    end
                end
                if (rtry_vld && exp_rdy) begin
                    k = decode(ab);
                    if (inv || k == 4'b0000) begin
                        e_drop = 1'b1;
                    end else if (k == 4'b0100) begin
                        armed[ch]   = 1'b1;
                        fire_at[ch] = cyc + 2 + int'(mmio_backoff_limit);
                    end else begin
                        fire(ch, k);
                    end
                end
                for (int i = 0; i < NS; i++) e_busy[i] = armed[i];
                abort_prev = ab;
                hold = rtry_vld && !exp_rdy;
            end
            @(posedge clock);
            cyc++;
        end
        @(negedge clock);
        chk("final_start", 64'(start_rtry_seq), 64'(e_start));
        chk("final_busy", 64'(backoff_busy), 64'(e_busy));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
